// File: rtl/console_ctrl.sv
// console_ctrl: TTY output FIFO with IDLE/SEND/GAP drain FSM plus keyboard latch; CONSOLE_ECHO_EN adds local echo
module console_ctrl #(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       tty_wr_en,
    input  logic [6:0] tty_wr_data,
    output logic       tty_ready,
    output logic       tty_dev_valid,
    output logic [6:0] tty_dev_data,
    input  logic       tty_dev_ack,
    output logic       tty_overflow,
    input  logic       kb_dev_valid,
    input  logic [6:0] kb_dev_data,
    output logic       kb_status,
    output logic [6:0] kb_data,
    input  logic       kb_read_en,
    output logic       kb_overrun
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;
    state_t        state;
    logic [6:0]    mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [AW:0]   count;
    logic          full, push, pop, drop;
    logic [6:0]    push_data;
    // count never exceeds DEPTH, a power of two, so its MSB alone means full
    assign full      = count[AW];
    assign tty_ready = ~full;
    assign pop       = (state == SEND) && tty_dev_ack;
`ifdef CONSOLE_ECHO_EN
    assign push      = !full && (tty_wr_en || kb_dev_valid);
    assign push_data = tty_wr_en ? tty_wr_data : kb_dev_data;
    assign drop      = (tty_wr_en && full) || (kb_dev_valid && (tty_wr_en || full));
`else
    assign push      = tty_wr_en && !full;
    assign push_data = tty_wr_data;
    assign drop      = tty_wr_en && full;
`endif
    always_ff @(posedge clk)
        if (push) mem[wptr] <= push_data;
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            wptr         <= '0;
            rptr         <= '0;
            count        <= '0;
            tty_overflow <= 1'b0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop) rptr <= rptr + 1'b1;
            if (push && !pop) count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
            if (drop) tty_overflow <= 1'b1;
        end
    // count and rptr are already post-pop when GAP decides whether to resend
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            state         <= IDLE;
            tty_dev_valid <= 1'b0;
            tty_dev_data  <= '0;
        end else begin
            case (state)
                IDLE, GAP: begin
                    if (count != '0) begin
                        state         <= SEND;
                        tty_dev_valid <= 1'b1;
                        tty_dev_data  <= mem[rptr];
                    end else begin
                        state <= IDLE;
                    end
                end
                SEND: begin
                    if (tty_dev_ack) begin
                        state         <= GAP;
                        tty_dev_valid <= 1'b0;
                    end
                end
                default: begin
                    state         <= IDLE;
                    tty_dev_valid <= 1'b0;
                end
            endcase
        end
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            kb_status  <= 1'b0;
            kb_data    <= '0;
            kb_overrun <= 1'b0;
        end else if (kb_dev_valid) begin
            kb_data   <= kb_dev_data;
            kb_status <= 1'b1;
            if (kb_status && !kb_read_en) kb_overrun <= 1'b1;
        end else if (kb_read_en) begin
            kb_status  <= 1'b0;
            kb_overrun <= 1'b0;
        end
endmodule

// File: doc/console_ctrl.md
CONSOLE_CTRL -- requirements
Module: console_ctrl

Interface
REQ-001 The block SHALL have one parameter: DEPTH, default 8, TTY FIFO entry count (power of two, 2..64).
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 tty_wr_en  in  1  CPU store strobe to TTY data register (driven from the IO decoder's TTY enable).
REQ-005 tty_wr_data  in  7  character written by the CPU.
REQ-006 tty_ready  out  1  high when the FIFO can accept a character (count < DEPTH).
REQ-007 tty_dev_valid  out  1  character presented to the terminal device.
REQ-008 tty_dev_data  out  7  character to the terminal device.
REQ-009 tty_dev_ack  in  1  device accepted the presented character.
REQ-010 tty_overflow  out  1  sticky flag: a push was dropped.
REQ-011 kb_dev_valid  in  1  one-cycle strobe: new keystroke from the keyboard device.
REQ-012 kb_dev_data  in  7  keystroke ASCII code.
REQ-013 kb_status  out  1  keystroke pending.
REQ-014 kb_data  out  7  held keystroke.
REQ-015 kb_read_en  in  1  CPU read of the keyboard data register.
REQ-016 kb_overrun  out  1  a keystroke was lost while one was pending.

Function
REQ-017 The TTY FIFO SHALL be circular, with read and write pointers wrapping modulo DEPTH and a count of width clog2(DEPTH)+1.
REQ-018 tty_ready SHALL equal (count < DEPTH), decoded from registered count (no combinational path from inputs).
REQ-019 A push SHALL occur when tty_wr_en is high and count < DEPTH at the start of the cycle; full is judged before any same-cycle pop.
REQ-020 tty_wr_en while full SHALL drop the character and set tty_overflow, even if a pop occurs that cycle.
REQ-021 The drain FSM SHALL have states IDLE, SEND and GAP.
REQ-022 IDLE->SEND when count > 0; tty_dev_valid SHALL be high only in SEND, with tty_dev_data = FIFO head.
REQ-023 In SEND, tty_dev_data SHALL be held stable until tty_dev_ack; tty_dev_ack high in SEND pops the head and moves to GAP.
REQ-024 GAP SHALL last exactly one cycle with tty_dev_valid low, then go to SEND if count > 0, else IDLE.
REQ-025 tty_dev_ack outside SEND SHALL be ignored.
REQ-026 Push and pop in the same cycle SHALL leave count unchanged; a push into an empty FIFO SHALL first appear on tty_dev_valid no earlier than the following cycle.
REQ-027 kb_dev_valid SHALL load kb_data <= kb_dev_data and set kb_status.
REQ-028 kb_read_en with no kb_dev_valid SHALL clear kb_status and kb_overrun; kb_data SHALL be held.
REQ-029 When kb_dev_valid and kb_read_en coincide, the new keystroke SHALL win: kb_status stays 1, kb_data updates, and kb_overrun is unchanged.
REQ-030 kb_dev_valid while kb_status = 1 and kb_read_en = 0 SHALL overwrite kb_data and set kb_overrun.
REQ-031 kb_read_en held for multiple cycles SHALL behave as repeated reads (idempotent clear).

Reset
REQ-032 reset_n low SHALL asynchronously force: FIFO empty, pointers 0, FSM IDLE, tty_dev_valid 0, tty_dev_data 0, tty_ready 1 and tty_overflow 0.
REQ-033 reset_n low SHALL also force kb_status 0, kb_data 0 and kb_overrun 0.
REQ-034 Reset asserted mid-SEND SHALL abort the transfer and discard the character; no ack after reset release SHALL pop.
REQ-035 After reset_n rises, the first push SHALL be accepted on the first clock edge.

Configuration
REQ-036 Macro CONSOLE_ECHO_EN defined: each kb_dev_valid SHALL also push kb_dev_data into the TTY FIFO (local echo).
REQ-037 With CONSOLE_ECHO_EN, a CPU write SHALL take priority over a same-cycle echo; the echo SHALL be dropped and set tty_overflow.
REQ-038 With CONSOLE_ECHO_EN, an echo into a full FIFO SHALL be dropped and set tty_overflow.
REQ-039 Without CONSOLE_ECHO_EN, keystrokes SHALL never enter the FIFO and there SHALL be no echo logic.

Verification
REQ-040 Reset release, write 0x41 then 0x42, ack each at 2nd cycle of valid -> device sees 0x41, one GAP cycle, then 0x42; FIFO ends empty, FSM IDLE.
REQ-041 DEPTH=8, ack held low, 9 writes 0x30..0x38 -> tty_ready falls after 8th; 0x38 dropped, tty_overflow=1; drain yields 0x30..0x37 in order.
REQ-042 FIFO full, write 0x55 coincident with ack -> 0x55 dropped, overflow set, count 7 after cycle.
REQ-043 kb strobe 0x61, then 0x62 with no read -> kb_data=0x62, kb_status=1, kb_overrun=1; kb_read_en -> status 0, overrun 0.
REQ-044 kb strobe 0x63 coincident with kb_read_en while status=1 -> kb_status stays 1, kb_data=0x63.
REQ-045 CONSOLE_ECHO_EN: kb strobe 0x7A alone -> 0x7A on tty_dev_data; kb 0x7B with tty_wr_en 0x21 same cycle -> only 0x21 queued, tty_overflow=1.
